// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - field bundle to RV64 instruction word encoder, two-stage valid/ready
// Optional immediate range checking is enabled by defining ENCODER_RANGE_CHECK_EN.
module instr_encoder #(
  parameter logic [63:0] PC_BASE    = 64'd0,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [63:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic [63:0] pc_out,
  output logic        err,
  input  logic        err_clr,
  output logic [15:0] word_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  // stage-1 register E
  logic        r_e_valid;
  logic [2:0]  r_op;
  logic [4:0]  r_rd, r_rs1, r_rs2;
  logic [2:0]  r_funct3;
  logic [6:0]  r_funct7;
  logic [63:0] r_imm;

  // output buffer
  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic [63:0]   r_pc;
  logic [15:0]   r_wc;
  logic          r_err;

  logic        w_fifo_full, w_pop, w_push, w_e_drain, w_accept;
  logic        w_reject, w_range_bad;
  logic [31:0] w_enc;

  assign w_fifo_full = (r_count == FULL_CNT);
  assign w_pop       = (r_count != '0) && out_ready;
  // a rejected bundle leaves E without needing FIFO space
  assign w_e_drain   = r_e_valid && (w_reject || !w_fifo_full || w_pop);
  assign w_push      = r_e_valid && !w_reject && (!w_fifo_full || w_pop);
  assign in_ready    = !(r_e_valid && w_fifo_full);
  assign w_accept    = in_valid && in_ready;
  assign w_reject    = (r_op == 3'd7) || w_range_bad;

  assign out_valid  = (r_count != '0);
  assign instr      = out_valid ? r_mem[r_rd_ptr] : 32'd0;
  assign pc_out     = r_pc;
  assign word_count = r_wc;
  assign err        = r_err;

  // stage 2: pack E into the instruction word; unused register fields stay zero
  always_comb begin
    w_enc = 32'd0;
    case (r_op)
      3'd0: w_enc = {r_funct7, r_rs2, r_rs1, r_funct3, r_rd, 7'b0110011};
      3'd1: w_enc = {r_imm[11:0], r_rs1, r_funct3, r_rd, 7'b0010011};
      3'd2: w_enc = {r_imm[11:0], r_rs1, 3'b011, r_rd, 7'b0000011};
      3'd3: w_enc = {r_imm[11:5], r_rs2, r_rs1, 3'b011, r_imm[4:0], 7'b0100011};
      3'd4: w_enc = {r_imm[12], r_imm[10:5], r_rs2, r_rs1, r_funct3,
                     r_imm[4:1], r_imm[11], 7'b1100011};
      3'd5: w_enc = {r_imm[20], r_imm[10:1], r_imm[11], r_imm[19:12], r_rd, 7'b1101111};
      3'd6: w_enc = {r_imm[11:0], r_rs1, 3'b000, r_rd, 7'b1100111};
      default: w_enc = 32'd0;
    endcase
  end

`ifdef ENCODER_RANGE_CHECK_EN
  logic signed [63:0] w_simm;
  assign w_simm = r_imm;

  // reject immediates that do not fit their field, and odd branch/jump offsets
  always_comb begin
    w_range_bad = 1'b0;
    case (r_op)
      3'd1, 3'd2, 3'd3, 3'd6:
        w_range_bad = (w_simm < -64'sd2048) || (w_simm > 64'sd2047);
      3'd4:
        w_range_bad = (w_simm < -64'sd4096) || (w_simm > 64'sd4094) || r_imm[0];
      3'd5:
        w_range_bad = (w_simm < -64'sd1048576) || (w_simm > 64'sd1048574) || r_imm[0];
      default: w_range_bad = 1'b0;
    endcase
  end
`else
  // high immediate bits are simply truncated away
  logic [42:0] w_unused_imm;
  assign w_unused_imm = r_imm[63:21];
  assign w_range_bad  = 1'b0;
`endif

  // stage 1 capture; E empties when its content moves on and nothing replaces it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_e_valid <= 1'b0;
      r_op      <= 3'd0;
      r_rd      <= 5'd0;
      r_rs1     <= 5'd0;
      r_rs2     <= 5'd0;
      r_funct3  <= 3'd0;
      r_funct7  <= 7'd0;
      r_imm     <= 64'd0;
    end else if (w_accept) begin
      r_e_valid <= 1'b1;
      r_op      <= op;
      r_rd      <= rd;
      r_rs1     <= rs1;
      r_rs2     <= rs2;
      r_funct3  <= funct3;
      r_funct7  <= funct7;
      r_imm     <= imm;
    end else if (w_e_drain) begin
      r_e_valid <= 1'b0;
    end
  end

  // FIFO storage needs no reset: occupancy is tracked by r_count
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_enc;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // PC tag and word counter advance on every pop, both wrapping naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= PC_BASE;
      r_wc <= 16'd0;
    end else if (w_pop) begin
      r_pc <= r_pc + 64'd4;
      r_wc <= r_wc + 16'd1;
    end
  end

  // sticky error; a rejection in the same cycle as a clear keeps it set
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      r_err <= 1'b0;
    else if (r_e_valid && w_reject) r_err <= 1'b1;
    else if (err_clr)               r_err <= 1'b0;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the instruction decoder: takes decoded fields (op class, register indices, funct3/funct7, 64-bit signed immediate) and produces the 32-bit RV64 instruction word.
- Covers the same classes the datapath executes: R, I-ALU, ld, sd, branch, jal, jalr.
- Used to load instruction memory from a test/boot sequencer, and for round-trip checking against the decoder.
- Two-stage valid/ready pipeline. Each emitted word is tagged with a running PC, which advances by 4 per word.

Parameters:
- PC_BASE, 64'd0, PC tagged on the first word after reset.
- FIFO_DEPTH, 2, output buffer entries (power of two, minimum 2).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle
- op  in  3  0=R 1=I-ALU 2=ld 3=sd 4=branch 5=jal 6=jalr 7=reserved
- rd  in  5  destination register
- rs1  in  5  source register 1
- rs2  in  5  source register 2
- funct3  in  3  used for R, I-ALU, branch; ignored for other ops
- funct7  in  7  used for R only
- imm  in  64  signed immediate or byte offset
- out_valid  out  1  encoded word available
- out_ready  in  1  consumer takes the word
- instr  out  32  encoded instruction
- pc_out  out  64  address tagged to instr
- err  out  1  sticky: a bundle was rejected
- err_clr  in  1  synchronous clear of err
- word_count  out  16  number of words emitted, wraps

Behaviour:
- Reset (async) values: out_valid=0, instr=0, pc_out=PC_BASE, err=0, word_count=0, in_ready=1, FIFO empty, stage-1 register empty. Any in-flight bundle is discarded.
- Stage 1 (register E) captures a bundle when in_valid && in_ready.
- Stage 2 encodes E combinationally and pushes the result into the output FIFO on the next edge. Latency from acceptance to out_valid is 2 cycles.
- Opcode and funct3 per op:
  - R: 0110011, {funct7,rs2,rs1,funct3,rd,op}.
  - I-ALU: 0010011.
  - ld: 0000011 with funct3 forced to 011.
  - sd: 0100011 with funct3 forced to 011.
  - branch: 1100011.
  - jal: 1101111.
  - jalr: 1100111 with funct3 forced to 000.
- Immediate bit placement per op:
  - I/ld/jalr: instr[31:20]=imm[11:0].
  - sd: instr[31:25]=imm[11:5], instr[11:7]=imm[4:0].
  - branch: instr[31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - jal: instr[31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
- Register fields an op does not use are 0: rs2 for I/ld/jalr; rd for sd/branch; rs1, rs2 and funct3 for jal.
- in_ready = !(E full && FIFO full). E drains into the FIFO in the same cycle the FIFO pops when it is full. Full throughput is 1 word/cycle when out_ready=1.
- Output side:
  - On pop (out_valid && out_ready): pc_out += 4 and word_count += 1.
  - pc_out wraps at 2^64.
  - word_count wraps 0xFFFF -> 0x0000.
- Rejection:
  - op=7 is always rejected.
  - A rejected bundle is dropped in stage 2, sets err, produces no FIFO entry and does not advance pc_out.
- err_clr and a new rejection in the same cycle: err remains 1 (set wins).
- Ordering is preserved strictly. No bundle is lost under backpressure.

Optional Feature:
- Macro: ENCODER_RANGE_CHECK_EN.
- Defined: stage 2 also rejects any of the following (sets err, drops the bundle):
  - I/ld/sd/jalr immediate outside -2048..2047.
  - branch offset outside -4096..4094, or odd.
  - jal offset outside -1048576..1048574, or odd.
- Undefined: these immediates are silently truncated to the field bits, bit 0 is ignored for branch/jal, and only op=7 sets err.

Test Plan:
- Basic encodes, after reset with PC_BASE=0, out_ready=1:
  - op=1 rd=1 rs1=0 funct3=0 imm=5 -> instr=0x00500093, pc_out=0, 2 cycles after acceptance.
  - op=3 rs1=3 rs2=2 imm=8 -> 0x0021B423, pc_out=4.
  - op=4 rs1=1 rs2=2 funct3=0 imm=-8 -> 0xFE208CE3.
  - op=5 rd=1 imm=16 -> 0x010000EF.
- Backpressure: hold out_ready=0 and issue 4 bundles -> in_ready falls after FIFO_DEPTH+1 accepts. Release -> all words emerge in order, pc_out 0,4,8,..., word_count ends at the number accepted.
- Reserved op: op=7 -> no out_valid, err=1, pc_out unchanged. Pulse err_clr -> err=0. err_clr together with a second op=7 -> err stays 1.
- Range check: addi with imm=4096, and jal with imm=3:
  - With ENCODER_RANGE_CHECK_EN: err=1, no output.
  - Without: addi emits 0x00000093 (rd=1, rs1=0), jal emits its truncated, bit-0-dropped word, err=0.
- Reset mid-operation: assert reset with 2 words buffered -> out_valid=0 immediately. After release, pc_out=PC_BASE, word_count=0, and the next bundle encodes correctly.
- Wrap: preload via 65536 pops -> word_count returns to 0. pc_out continues at 0x40000.
